// File: rtl/y_pulse_monitor.sv
// -----------------------------------------------------------------------------
// y_pulse_monitor
//
// Purpose:
//   Watches the single-bit output y of the `example` block. It deglitches y,
//   strobes on each filtered rising edge, counts those edges in windows of
//   REPORT_EVERY, and offers one report per completed window on a valid/ready
//   interface. y_in is synchronous to clk, so there is no synchronizer.
//
// Optional feature macro: Y_FALL_DETECT_EN
//   When defined, adds the fall_pulse output, a one-cycle strobe on each
//   filtered 1->0 transition. Counting and reporting do not change.
//
// Parameters:
//   STABLE_CYCLES : consecutive differing samples before filt_y follows y_in (1..255)
//   CNT_W         : width of pulse_cnt and rpt_count
//   REPORT_EVERY  : filtered rising edges per report window (1..2^CNT_W-1)
//
// Ports:
//   clk        in   rising-edge clock
//   rst_n      in   synchronous active-low reset
//   en         in   monitor enable (low freezes the filter and counting)
//   y_in       in   raw y from the `example` block
//   filt_y     out  deglitched y
//   rise_pulse out  one-cycle strobe on a filtered 0->1 transition
//   fall_pulse out  one-cycle strobe on a filtered 1->0 transition (Y_FALL_DETECT_EN only)
//   pulse_cnt  out  rising edges seen in the current window
//   rpt_valid  out  report available
//   rpt_ready  in   downstream accepts the report
//   rpt_count  out  count carried by the report
//   overflow   out  sticky: a window completed while a report was still pending
//   fsm_state  out  debug view of the report FSM (0 = COUNT, 1 = REPORT)
//
// Report handshake:
//   A report transfers at a rising clk edge where rpt_valid && rpt_ready.
//   While rpt_valid is high, rpt_count is held stable until that transfer.
//   rpt_valid does not depend on rpt_ready, and rpt_ready is ignored while
//   rpt_valid is low. The handshake keeps working while en is low.
// -----------------------------------------------------------------------------
module y_pulse_monitor #(
  parameter int STABLE_CYCLES = 4,
  parameter int CNT_W         = 8,
  parameter int REPORT_EVERY  = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             y_in,
  output logic             filt_y,
  output logic             rise_pulse,
`ifdef Y_FALL_DETECT_EN
  output logic             fall_pulse,
`endif
  output logic [CNT_W-1:0] pulse_cnt,
  output logic             rpt_valid,
  input  logic             rpt_ready,
  output logic [CNT_W-1:0] rpt_count,
  output logic             overflow,
  output logic             fsm_state
);

  localparam logic [7:0]       STAB_LAST = 8'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] WIN_LAST  = CNT_W'(REPORT_EVERY - 1);
  localparam logic [CNT_W-1:0] WIN_SIZE  = CNT_W'(REPORT_EVERY);

  typedef enum logic {
    COUNT  = 1'b0,
    REPORT = 1'b1
  } state_t;

  state_t           state, state_nxt;
  logic [7:0]       stab_cnt;
  logic             qualify;
  logic             rise_now;
  logic             window_end;
  logic             rpt_valid_nxt;
  logic [CNT_W-1:0] rpt_count_nxt;
  logic             overflow_nxt;

  // qualify is true on the edge where filt_y will change to follow y_in.
  assign qualify    = en && (y_in != filt_y) && (stab_cnt == STAB_LAST);
  assign rise_now   = qualify && y_in;
  assign window_end = rise_now && (pulse_cnt == WIN_LAST);
  assign fsm_state  = state;

  // Deglitch filter, rise strobe and window counter.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stab_cnt   <= '0;
      filt_y     <= 1'b0;
      rise_pulse <= 1'b0;
      pulse_cnt  <= '0;
    end else begin
      rise_pulse <= rise_now;
      // Disabled or matching samples restart the qualification run.
      if (!en || (y_in == filt_y)) begin
        stab_cnt <= '0;
      end else if (stab_cnt == STAB_LAST) begin
        filt_y   <= y_in;
        stab_cnt <= '0;
      end else begin
        stab_cnt <= stab_cnt + 8'd1;
      end
      // The count wraps to zero at the window end, whether or not the
      // previous report has been taken.
      if (rise_now) begin
        pulse_cnt <= window_end ? '0 : pulse_cnt + CNT_W'(1);
      end
    end
  end

`ifdef Y_FALL_DETECT_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fall_pulse <= 1'b0;
    end else begin
      fall_pulse <= qualify && !y_in;
    end
  end
`endif

  // Report FSM: state register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= COUNT;
      rpt_valid <= 1'b0;
      rpt_count <= '0;
      overflow  <= 1'b0;
    end else begin
      state     <= state_nxt;
      rpt_valid <= rpt_valid_nxt;
      rpt_count <= rpt_count_nxt;
      overflow  <= overflow_nxt;
    end
  end

  // Report FSM: next state and report outputs.
  always_comb begin
    state_nxt     = state;
    rpt_valid_nxt = rpt_valid;
    rpt_count_nxt = rpt_count;
    overflow_nxt  = overflow;
    unique case (state)
      COUNT: begin
        if (window_end) begin
          rpt_valid_nxt = 1'b1;
          rpt_count_nxt = WIN_SIZE;
          state_nxt     = REPORT;
        end
      end
      REPORT: begin
        if (window_end) begin
          // Taking the old report on this edge makes room for the new one.
          // Otherwise the new window is lost and flagged.
          if (rpt_ready) begin
            rpt_valid_nxt = 1'b1;
            rpt_count_nxt = WIN_SIZE;
          end else begin
            overflow_nxt = 1'b1;
          end
        end else if (rpt_ready) begin
          rpt_valid_nxt = 1'b0;
          state_nxt     = COUNT;
        end
      end
      default: state_nxt = COUNT;
    endcase
  end

endmodule

// File: tb/tb_y_pulse_monitor.sv
module tb_y_pulse_monitor;

  // ---------------------------------------------------------------- clock/reset
  logic       clk = 1'b0;
  logic       rst_n, en, y_in, rpt_ready;
  logic       filt_y, rise_pulse, rpt_valid, overflow, fsm_state;
  logic [7:0] pulse_cnt, rpt_count;
`ifdef Y_FALL_DETECT_EN
  logic       fall_pulse;
`endif

  always #5 clk = ~clk;

  y_pulse_monitor #(
    .STABLE_CYCLES(4),
    .CNT_W        (8),
    .REPORT_EVERY (3)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .y_in      (y_in),
    .filt_y    (filt_y),
    .rise_pulse(rise_pulse),
`ifdef Y_FALL_DETECT_EN
    .fall_pulse(fall_pulse),
`endif
    .pulse_cnt (pulse_cnt),
    .rpt_valid (rpt_valid),
    .rpt_ready (rpt_ready),
    .rpt_count (rpt_count),
    .overflow  (overflow),
    .fsm_state (fsm_state)
  );

  // ---------------------------------------------------------------- vectors
  typedef struct {
    int         n;
    logic       rst_n, en, y, rdy;
    logic       e_filt, e_rise, e_fall;
    logic [7:0] e_cnt;
    logic       e_val;
    logic [7:0] e_rc;
    logic       e_ovf, e_st;
  } vec_t;

  vec_t vecs[$];

  int n_checks = 0;
  int n_pass   = 0;

  task automatic add(input int n, input logic r, input logic e, input logic y,
                     input logic rd, input logic f, input logic ri, input logic fa,
                     input logic [7:0] c, input logic v, input logic [7:0] rc,
                     input logic o, input logic s);
    vec_t t;
    t.n = n; t.rst_n = r; t.en = e; t.y = y; t.rdy = rd;
    t.e_filt = f; t.e_rise = ri; t.e_fall = fa;
    t.e_cnt = c; t.e_val = v; t.e_rc = rc; t.e_ovf = o; t.e_st = s;
    vecs.push_back(t);
  endtask

  // One clean filtered pulse with en=1, rpt_ready=0: checked after the rise
  // edge and after the fall edge. Arguments are the state after the rise.
  task automatic add_pulse(input logic [7:0] c, input logic v, input logic [7:0] rc,
                           input logic o, input logic s);
    add(4, 1, 1, 1, 0, 1, 1, 0, c, v, rc, o, s);
    add(4, 1, 1, 0, 0, 0, 0, 1, c, v, rc, o, s);
  endtask

  // ---------------------------------------------------------------- driver
  task automatic drive(input logic r, input logic e, input logic y, input logic rd,
                       input int n);
    for (int i = 0; i < n; i++) begin
      rst_n = r; en = e; y_in = y; rpt_ready = rd;
      @(posedge clk);
      #1;
    end
  endtask

  // ---------------------------------------------------------------- scoreboard
  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic chk_all(input string tag, input vec_t t);
    chk({tag, " filt_y"},     {7'd0, filt_y},     {7'd0, t.e_filt});
    chk({tag, " rise_pulse"}, {7'd0, rise_pulse}, {7'd0, t.e_rise});
`ifdef Y_FALL_DETECT_EN
    chk({tag, " fall_pulse"}, {7'd0, fall_pulse}, {7'd0, t.e_fall});
`endif
    chk({tag, " pulse_cnt"},  pulse_cnt,          t.e_cnt);
    chk({tag, " rpt_valid"},  {7'd0, rpt_valid},  {7'd0, t.e_val});
    chk({tag, " rpt_count"},  rpt_count,          t.e_rc);
    chk({tag, " overflow"},   {7'd0, overflow},   {7'd0, t.e_ovf});
    chk({tag, " fsm_state"},  {7'd0, fsm_state},  {7'd0, t.e_st});
  endtask

  task automatic run_vec(input string tag, input vec_t t);
    drive(t.rst_n, t.en, t.y, t.rdy, t.n);
    chk_all(tag, t);
  endtask

  // ---------------------------------------------------------------- test
  initial begin
    vec_t h;
    rst_n = 1'b0; en = 1'b0; y_in = 1'b0; rpt_ready = 1'b0;

    // Reset
    add(2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    // Deglitch: 3-cycle high is rejected, 4-cycle high is accepted
    add(3, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    add(1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    add(3, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    add(1, 1, 1, 1, 0, 1, 1, 0, 1, 0, 0, 0, 0);
    add(1, 1, 1, 1, 0, 1, 0, 0, 1, 0, 0, 0, 0);
    add(3, 1, 1, 0, 0, 1, 0, 0, 1, 0, 0, 0, 0);
    add(1, 1, 1, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0);
    add(1, 1, 1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
    // Window/report
    add_pulse(2, 0, 0, 0, 0);
    add_pulse(0, 1, 3, 0, 1);
    add(1, 1, 1, 0, 1, 0, 0, 0, 0, 0, 3, 0, 0);   // handshake
    add(2, 1, 1, 0, 1, 0, 0, 0, 0, 0, 3, 0, 0);   // ready without valid ignored
    // Simultaneous handshake and window end
    add_pulse(1, 0, 3, 0, 0);
    add_pulse(2, 0, 3, 0, 0);
    add_pulse(0, 1, 3, 0, 1);
    add_pulse(1, 1, 3, 0, 1);
    add_pulse(2, 1, 3, 0, 1);
    add(3, 1, 1, 1, 0, 0, 0, 0, 2, 1, 3, 0, 1);
    add(1, 1, 1, 1, 1, 1, 1, 0, 0, 1, 3, 0, 1);   // rise edge with ready
    add(4, 1, 1, 0, 0, 0, 0, 1, 0, 1, 3, 0, 1);
    add(1, 1, 1, 0, 1, 0, 0, 0, 0, 0, 3, 0, 0);
    // Reset, then overflow
    add(1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int k = 1; k <= 6; k++)
      add_pulse(8'(k % 3), k >= 3, (k >= 3) ? 8'd3 : 8'd0, k >= 6, k >= 3);
    add(1, 1, 1, 0, 1, 0, 0, 0, 0, 0, 3, 1, 0);   // handshake, overflow sticky
    // en=0 clears the qualification run
    add(3, 1, 1, 1, 0, 0, 0, 0, 0, 0, 3, 1, 0);
    add(1, 1, 0, 1, 0, 0, 0, 0, 0, 0, 3, 1, 0);
    add(1, 1, 1, 1, 0, 0, 0, 0, 0, 0, 3, 1, 0);
    add(2, 1, 1, 1, 0, 0, 0, 0, 0, 0, 3, 1, 0);
    add(1, 1, 1, 1, 0, 1, 1, 0, 1, 0, 3, 1, 0);
    add(4, 1, 1, 0, 0, 0, 0, 1, 1, 0, 3, 1, 0);
    add_pulse(2, 0, 3, 1, 0);
    add_pulse(0, 1, 3, 1, 1);
    add(1, 1, 0, 0, 1, 0, 0, 0, 0, 0, 3, 1, 0);   // handshake while en=0
    // Build rpt_valid=1 with pulse_cnt=2
    add_pulse(1, 0, 3, 1, 0);
    add_pulse(2, 0, 3, 1, 0);
    add_pulse(0, 1, 3, 1, 1);
    add_pulse(1, 1, 3, 1, 1);
    add_pulse(2, 1, 3, 1, 1);

    for (int i = 0; i < vecs.size(); i++)
      run_vec($sformatf("vec%0d", i), vecs[i]);

    // en=0 with y_in toggling: everything frozen, report still pending
    h = '{n: 1, rst_n: 1, en: 0, y: 0, rdy: 0, e_filt: 0, e_rise: 0, e_fall: 0,
          e_cnt: 8'd2, e_val: 1, e_rc: 8'd3, e_ovf: 1, e_st: 1};
    for (int i = 0; i < 20; i++) begin
      drive(1, 0, i[0], 0, 1);
      chk_all($sformatf("en_off%0d", i), h);
    end
    drive(1, 0, 1, 0, 8);
    chk_all("en_off_hold", h);

    // Reset while a report is pending
    h = '{n: 1, rst_n: 0, en: 1, y: 0, rdy: 0, e_filt: 0, e_rise: 0, e_fall: 0,
          e_cnt: 8'd0, e_val: 0, e_rc: 8'd0, e_ovf: 0, e_st: 0};
    drive(0, 1, 0, 0, 1);
    chk_all("mid_rpt_reset", h);
    drive(1, 1, 0, 0, 1);
    chk_all("after_reset", h);

    // filt_y=1 holds while en=0, and no fall is reported
    h = '{n: 1, rst_n: 1, en: 1, y: 1, rdy: 0, e_filt: 1, e_rise: 1, e_fall: 0,
          e_cnt: 8'd1, e_val: 0, e_rc: 8'd0, e_ovf: 0, e_st: 0};
    drive(1, 1, 1, 0, 4);
    chk_all("hold_rise", h);
    h.e_rise = 0;
    drive(1, 0, 0, 0, 8);
    chk_all("hold_high_en_off", h);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/y_pulse_monitor.md
Name: y_pulse_monitor

Overview:
- Downstream consumer of the single-bit combinational output y of the `example` logic block.
- Registers and deglitches y, detects filtered rising edges and counts them.
- After every REPORT_EVERY pulses, presents the window count on a valid/ready report interface to a downstream collector.
- Single clock domain; y_in is treated as synchronous to clk, so no synchronizer is used.

Parameters:
- STABLE_CYCLES, 4, consecutive cycles y_in must differ from filt_y before filt_y follows it; legal range 1..255.
- CNT_W, 8, width of pulse_cnt and rpt_count.
- REPORT_EVERY, 16, filtered rising edges per report window; legal range 1..2^CNT_W-1.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous, active-low reset.
- en  input  1  monitor enable; when low, filter and counting are frozen.
- y_in  input  1  y output of the `example` block.
- filt_y  output  1  deglitched y.
- rise_pulse  output  1  one-cycle strobe on a filtered 0->1 transition.
- pulse_cnt  output  CNT_W  rising edges seen in the current window.
- rpt_valid  output  1  report available.
- rpt_ready  input  1  downstream accepts the report.
- rpt_count  output  CNT_W  count carried by the report (always REPORT_EVERY when valid).
- overflow  output  1  sticky flag: a window completed while a report was still pending.

Behaviour:
- Reset: rst_n low at a rising edge clears all state on that edge.
  - filt_y=0, rise_pulse=0, pulse_cnt=0, rpt_valid=0, rpt_count=0, overflow=0.
  - Internal stab_cnt=0; FSM goes to COUNT.
  - Reset mid-report drops the pending report without a handshake.
- Filter (en=1):
  - If y_in==filt_y: stab_cnt<=0.
  - Else, if stab_cnt==STABLE_CYCLES-1: filt_y<=y_in and stab_cnt<=0.
  - Else: stab_cnt<=stab_cnt+1.
  - Latency: a new level first sampled at edge k appears on filt_y after edge k+STABLE_CYCLES-1.
  - Any sample matching filt_y restarts qualification.
- Filter (en=0): stab_cnt<=0, filt_y holds, rise_pulse=0, no counting.
  - The report handshake still operates while en=0.
- rise_pulse: registered; high for exactly the cycle in which filt_y first reads 1 after being 0. Never high two cycles in a row.
- pulse_cnt: increments at the same edge that sets filt_y 0->1, so it is already incremented while rise_pulse is high.
- Window end: if the increment would make pulse_cnt==REPORT_EVERY, pulse_cnt<=0 instead.
- FSM states COUNT and REPORT:
  - COUNT, window end: rpt_count<=REPORT_EVERY, rpt_valid<=1, go to REPORT.
  - REPORT: rpt_valid and rpt_count stay stable until handshake; counting continues into pulse_cnt.
  - REPORT, rpt_valid&rpt_ready at an edge with no window end: rpt_valid<=0, go to COUNT.
  - REPORT, window end without handshake: overflow<=1 (sticky until reset), pulse_cnt<=0, rpt_count unchanged, stay in REPORT.
  - REPORT, handshake and window end at the same edge: new report loaded, rpt_valid stays 1, stay in REPORT, overflow not set.
- rpt_ready while rpt_valid=0 is ignored.
- REPORT_EVERY=1: every rising edge produces a report.

Optional Feature:
- Macro: Y_FALL_DETECT_EN.
- Defined: adds output port fall_pulse (1 bit), the one-cycle registered strobe for the cycle in which filt_y first reads 0 after being 1. Reset value 0; forced 0 while en=0. It does not affect counting or reporting.
- Undefined: the port and its logic are absent; all other behaviour is identical.

Test Plan:
- Deglitch (STABLE_CYCLES=4, en=1): y_in high for 3 cycles then low -> filt_y stays 0, pulse_cnt=0. y_in high for 4 cycles -> filt_y=1 after the 4th edge, rise_pulse high 1 cycle, pulse_cnt=1.
- Window/report (REPORT_EVERY=3, rpt_ready=0): 3 clean pulses -> on the 3rd, rpt_valid=1, rpt_count=3, pulse_cnt=0. Raise rpt_ready for 1 cycle -> rpt_valid=0 next cycle, FSM back in COUNT.
- Overflow (REPORT_EVERY=3, rpt_ready=0): 6 pulses -> rpt_valid=1, rpt_count=3, overflow=1, pulse_cnt=0. Handshake -> rpt_valid=0, overflow stays 1.
- Simultaneous (REPORT_EVERY=3): report pending with pulse_cnt=2; rpt_ready=1 at the edge of the 3rd rise -> rpt_valid stays 1, rpt_count=3, overflow=0.
- Enable/reset: en=0 with y_in toggling for 20 cycles -> filt_y, pulse_cnt unchanged. rst_n=0 for one edge while rpt_valid=1, pulse_cnt=2 -> all outputs 0 next cycle.
- Y_FALL_DETECT_EN defined: filtered 1->0 -> fall_pulse high exactly 1 cycle; pulse_cnt unchanged.
